// File: rtl/aes_spi_pkg.sv
// Shared constants, key-mode codes and FSM state encoding for the AES SPI subordinate deframer.
package aes_spi_pkg;

    localparam logic [1:0] KM_128 = 2'b00;
    localparam logic [1:0] KM_192 = 2'b01;
    localparam logic [1:0] KM_256 = 2'b10;

    // Key frames carry a 2-bit mode prefix ahead of the key bits.
    localparam int unsigned KEY128_BITS = 130;
    localparam int unsigned KEY192_BITS = 194;
    localparam int unsigned KEY256_BITS = 258;

    localparam int unsigned CNT_BITS = 9;

    typedef enum logic [1:0] {
        ST_KEY      = 2'd0,
        ST_MSG      = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_READ     = 2'd3
    } state_e;

    function automatic logic [CNT_BITS-1:0] cnt_sat_inc(input logic [CNT_BITS-1:0] cnt);
        if (cnt == {CNT_BITS{1'b1}}) begin
            return cnt;
        end else begin
            return cnt + 9'd1;
        end
    endfunction

endpackage

// File: rtl/aes_spi_sync.sv
// N-stage input synchronizer with rise/fall detection on the synchronized value.
module aes_spi_sync
    import aes_spi_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_r;
    logic              prev_r;

    // Synchronizer chain plus one history flop for edge detection; all reset low so that
    // no falling edge can be seen after reset until the line has been observed high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_r <= '0;
            prev_r  <= 1'b0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
            prev_r  <= chain_r[STAGES-1];
        end
    end

    assign q    = chain_r[STAGES-1];
    assign rise = chain_r[STAGES-1] & ~prev_r;
    assign fall = ~chain_r[STAGES-1] & prev_r;

endmodule

// File: rtl/aes_spi_sub_frame.sv
// SPI subordinate deframer for the AES cores: key/message frames in, result frame out on miso.
// Define AES_SPI_FRAME_ERR_EN to add the frame_err pulse and saturating err_cnt outputs.
module aes_spi_sub_frame
    import aes_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MSG_BITS    = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs_n,
    input  logic                sclk,
    input  logic                mosi,
    output logic                miso,
    output logic [255:0]        key,
    output logic [1:0]          key_mode,
    output logic                key_valid,
    output logic [MSG_BITS-1:0] msg,
    output logic                msg_valid,
    input  logic [MSG_BITS-1:0] res,
    input  logic                res_valid,
    output logic                res_ready,
    output logic                busy
`ifdef AES_SPI_FRAME_ERR_EN
    ,
    output logic                frame_err,
    output logic [7:0]          err_cnt
`endif
);

    localparam int unsigned RX_BITS = KEY256_BITS;
    localparam logic [CNT_BITS-1:0] MSG_CNT = CNT_BITS'(MSG_BITS);

    logic cs_q_s, cs_rise_s, cs_fall_s;
    logic sclk_rise_s, sclk_fall_s;
    logic mosi_q_s;

    aes_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst(rst), .d(cs_n), .q(cs_q_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );
    aes_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    aes_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_q_s), .rise(), .fall()
    );

    state_e                state_r, state_next_s;
    logic                  in_frame_r, in_frame_next_s;
    logic [CNT_BITS-1:0]   cnt_r, cnt_next_s;
    logic [RX_BITS-1:0]    rx_r, rx_next_s;
    logic [MSG_BITS-1:0]   tx_r, tx_next_s, res_hold_r;
    logic                  bit_s, end_s;
    logic                  k128_s, k192_s, k256_s;
    logic [255:0]          key_sel_s;
    logic [1:0]            mode_sel_s;
    logic                  key_load_s, msg_load_s, tx_load_s, tx_reload_s, discard_s;
    logic                  miso_r, key_valid_r, msg_valid_r, res_ready_r;
    logic [255:0]          key_r;
    logic [1:0]            key_mode_r;
    logic [MSG_BITS-1:0]   msg_r;

    // in_frame only opens on a genuine cs_n fall, so a frame cut by reset stays ignored.
    assign bit_s = in_frame_r & sclk_rise_s;
    assign end_s = in_frame_r & cs_rise_s;

    // Next capture state; the last sclk rise of a frame is folded in before frame evaluation.
    always_comb begin
        cnt_next_s      = cnt_r;
        rx_next_s       = rx_r;
        in_frame_next_s = in_frame_r;
        if (cs_fall_s) begin
            cnt_next_s = 9'd0;
        end else if (bit_s) begin
            cnt_next_s = cnt_sat_inc(cnt_r);
        end else begin
            cnt_next_s = cnt_r;
        end
        if (bit_s) begin
            rx_next_s = {rx_r[RX_BITS-2:0], mosi_q_s};
        end else begin
            rx_next_s = rx_r;
        end
        if (cs_fall_s) begin
            in_frame_next_s = 1'b1;
        end else if (cs_rise_s) begin
            in_frame_next_s = 1'b0;
        end else begin
            in_frame_next_s = in_frame_r;
        end
    end

    assign k128_s = (cnt_next_s == CNT_BITS'(KEY128_BITS)) && (rx_next_s[KEY128_BITS-1 -: 2] == KM_128);
    assign k192_s = (cnt_next_s == CNT_BITS'(KEY192_BITS)) && (rx_next_s[KEY192_BITS-1 -: 2] == KM_192);
    assign k256_s = (cnt_next_s == CNT_BITS'(KEY256_BITS)) && (rx_next_s[KEY256_BITS-1 -: 2] == KM_256);

    // Left-align the key payload of whichever key frame length matched.
    always_comb begin
        key_sel_s  = {rx_next_s[127:0], 128'd0};
        mode_sel_s = KM_128;
        if (k256_s) begin
            key_sel_s  = rx_next_s[255:0];
            mode_sel_s = KM_256;
        end else if (k192_s) begin
            key_sel_s  = {rx_next_s[191:0], 64'd0};
            mode_sel_s = KM_192;
        end else begin
            key_sel_s  = {rx_next_s[127:0], 128'd0};
            mode_sel_s = KM_128;
        end
    end

    // FSM next state and the one-cycle load/discard strobes.
    always_comb begin
        state_next_s = state_r;
        key_load_s   = 1'b0;
        msg_load_s   = 1'b0;
        tx_load_s    = 1'b0;
        tx_reload_s  = 1'b0;
        discard_s    = 1'b0;
        case (state_r)
            ST_KEY: begin
                if (end_s && (k128_s || k192_s || k256_s)) begin
                    key_load_s   = 1'b1;
                    state_next_s = ST_MSG;
                end else if (end_s) begin
                    discard_s = 1'b1;
                end else begin
                    state_next_s = ST_KEY;
                end
            end
            ST_MSG: begin
                if (end_s && (cnt_next_s == MSG_CNT)) begin
                    msg_load_s   = 1'b1;
                    state_next_s = ST_WAIT_RES;
                end else if (end_s) begin
                    discard_s = 1'b1;
                end else begin
                    state_next_s = ST_MSG;
                end
            end
            ST_WAIT_RES: begin
                if (res_valid) begin
                    tx_load_s    = 1'b1;
                    state_next_s = ST_READ;
                end else begin
                    state_next_s = ST_WAIT_RES;
                end
                discard_s = end_s;
            end
            ST_READ: begin
                if (end_s && (cnt_next_s == MSG_CNT)) begin
                    state_next_s = ST_KEY;
                end else if (end_s) begin
                    tx_reload_s = 1'b1;
                    discard_s   = 1'b1;
                end else begin
                    state_next_s = ST_READ;
                end
            end
            default: begin
                state_next_s = ST_KEY;
            end
        endcase
    end

    // Result shifter: load on handshake, reload after a short read, shift on each sclk fall.
    always_comb begin
        tx_next_s = tx_r;
        if (tx_load_s) begin
            tx_next_s = res;
        end else if (tx_reload_s) begin
            tx_next_s = res_hold_r;
        end else if (in_frame_r && sclk_fall_s && (state_r == ST_READ)) begin
            tx_next_s = {tx_r[MSG_BITS-2:0], 1'b0};
        end else begin
            tx_next_s = tx_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_KEY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_frame_r <= 1'b0;
            cnt_r      <= 9'd0;
            rx_r       <= '0;
            tx_r       <= '0;
            res_hold_r <= '0;
        end else begin
            in_frame_r <= in_frame_next_s;
            cnt_r      <= cnt_next_s;
            rx_r       <= rx_next_s;
            tx_r       <= tx_next_s;
            res_hold_r <= tx_load_s ? res : res_hold_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_r      <= 1'b0;
            key_r       <= 256'd0;
            key_mode_r  <= 2'b00;
            key_valid_r <= 1'b0;
            msg_r       <= '0;
            msg_valid_r <= 1'b0;
            res_ready_r <= 1'b0;
        end else begin
            miso_r      <= (in_frame_next_s && (state_next_s == ST_READ)) ? tx_next_s[MSG_BITS-1] : 1'b0;
            key_r       <= key_load_s ? key_sel_s : key_r;
            key_mode_r  <= key_load_s ? mode_sel_s : key_mode_r;
            key_valid_r <= key_load_s;
            msg_r       <= msg_load_s ? rx_next_s[MSG_BITS-1:0] : msg_r;
            msg_valid_r <= msg_load_s;
            res_ready_r <= (state_next_s == ST_WAIT_RES);
        end
    end

    assign miso      = miso_r;
    assign key       = key_r;
    assign key_mode  = key_mode_r;
    assign key_valid = key_valid_r;
    assign msg       = msg_r;
    assign msg_valid = msg_valid_r;
    assign res_ready = res_ready_r;
    assign busy      = in_frame_r;

`ifdef AES_SPI_FRAME_ERR_EN
    logic       frame_err_r;
    logic [7:0] err_cnt_r;

    // Discard pulse and saturating discard counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_r <= 1'b0;
            err_cnt_r   <= 8'd0;
        end else begin
            frame_err_r <= discard_s;
            err_cnt_r   <= (discard_s && (err_cnt_r != 8'hFF)) ? err_cnt_r + 8'd1 : err_cnt_r;
        end
    end

    assign frame_err = frame_err_r;
    assign err_cnt   = err_cnt_r;
`endif

endmodule

// File: tb/tb_aes_spi_sub_frame.sv
// Randomized bench for aes_spi_sub_frame: drives mode-0 SPI frames and compares the outputs
// against a frame-level reference model of the key/message/result protocol.
module tb_aes_spi_sub_frame;

    localparam int HALF = 5;

    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] MSG1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] RES1 = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst, cs_n, sclk, mosi, miso;
    logic [255:0] key;
    logic [1:0]   key_mode;
    logic         key_valid, msg_valid, res_valid, res_ready, busy;
    logic [127:0] msg, res;
`ifdef AES_SPI_FRAME_ERR_EN
    logic         frame_err;
    logic [7:0]   err_cnt;
    int           fe_cnt = 0;
`endif

    int errors = 0;
    int checks = 0;
    int kv_cnt = 0;
    int mv_cnt = 0;

    // Reference model: 0 = expect key, 1 = expect message, 2 = awaiting result, 3 = read-out.
    int           phase;
    logic [255:0] m_key;
    logic [1:0]   m_mode;
    logic [127:0] m_msg, m_res;
    int           m_err;

    always #5 clk = ~clk;

    aes_spi_sub_frame dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso),
        .key(key), .key_mode(key_mode), .key_valid(key_valid),
        .msg(msg), .msg_valid(msg_valid),
        .res(res), .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
`ifdef AES_SPI_FRAME_ERR_EN
        , .frame_err(frame_err), .err_cnt(err_cnt)
`endif
    );

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (key_valid) kv_cnt <= kv_cnt + 1;
        if (msg_valid) mv_cnt <= mv_cnt + 1;
`ifdef AES_SPI_FRAME_ERR_EN
        if (frame_err) fe_cnt <= fe_cnt + 1;
`endif
    end

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        phase  = 0;
        m_key  = 256'd0;
        m_mode = 2'b00;
        m_msg  = 128'd0;
        m_res  = 128'd0;
        m_err  = 0;
    endtask

    task automatic check_zero(input string t);
        check_eq({t, "_key"}, key, 256'd0);
        check_eq({t, "_key_mode"}, {254'd0, key_mode}, 256'd0);
        check_eq({t, "_strobes"}, {252'd0, key_valid, msg_valid, res_ready, busy}, 256'd0);
        check_eq({t, "_msg"}, {128'd0, msg}, 256'd0);
        check_eq({t, "_miso"}, {255'd0, miso}, 256'd0);
`ifdef AES_SPI_FRAME_ERR_EN
        check_eq({t, "_err"}, {247'd0, frame_err, err_cnt}, 256'd0);
`endif
    endtask

    // Mode-0 frame, MSB first; miso sampled just before each rise. rst_at >= 0 resets mid-frame.
    task automatic send_frame(input logic [257:0] bits, input int n, input int rst_at,
                              output logic [127:0] mbits);
        bit did_rst = 1'b0;
        mbits = 128'd0;
        cs_n  = 1'b0;
        for (int i = 0; i < n; i++) begin
            mosi = bits[n-1-i];
            tick(HALF);
            if (i == rst_at) begin
                rst = 1'b1;
                tick(2);
                check_zero("midrst");
                model_reset();
                rst = 1'b0;
                did_rst = 1'b1;
                tick(2);
                check_eq("busy_after_rst", {255'd0, busy}, 256'd0);
            end
            mbits = {mbits[126:0], miso};
            sclk  = 1'b1;
            tick(HALF);
            sclk  = 1'b0;
        end
        mosi = 1'b0;
        tick(HALF);
        check_eq("busy_in_frame", {255'd0, busy}, {255'd0, ~did_rst});
        cs_n = 1'b1;
        tick(12);
    endtask

    task automatic run_frame(input logic [257:0] bits, input int n);
        int           kv0, mv0, exp_kv, exp_mv, exp_err;
        logic [127:0] mb;
        logic [257:0] one258, mask258, tmp;
        logic [255:0] mask256;
        logic [1:0]   md;
        int           need;
`ifdef AES_SPI_FRAME_ERR_EN
        int           fe0 = fe_cnt;
`endif
        kv0 = kv_cnt;
        mv0 = mv_cnt;
        exp_kv = 0; exp_mv = 0; exp_err = 0;
        send_frame(bits, n, -1, mb);
        case (phase)
            0: begin
                tmp  = bits >> (n - 2);
                md   = tmp[1:0];
                need = (md == 2'b00) ? 130 : (md == 2'b01) ? 194 : (md == 2'b10) ? 258 : 0;
                if (n == need) begin
                    one258  = 258'd1;
                    mask258 = (one258 << (n - 2)) - one258;
                    tmp     = (bits & mask258) << (256 - (n - 2));
                    m_key   = tmp[255:0];
                    m_mode  = md;
                    exp_kv  = 1;
                    phase   = 1;
                end else begin
                    exp_err = 1;
                end
            end
            1: begin
                if (n == 128) begin
                    m_msg  = bits[127:0];
                    exp_mv = 1;
                    phase  = 2;
                end else begin
                    exp_err = 1;
                end
            end
            2: exp_err = 1;
            3: begin
                if (n <= 128) begin
                    mask256 = (256'd1 << n) - 256'd1;
                    check_eq("read_miso", {128'd0, mb} & mask256, {128'd0, m_res} >> (128 - n));
                end
                if (n == 128) phase = 0;
                else exp_err = 1;
            end
            default: exp_err = 1;
        endcase
        if (exp_err != 0 && m_err < 255) m_err++;
        check_eq("key_valid_pulses", 256'(kv_cnt - kv0), 256'(exp_kv));
        check_eq("msg_valid_pulses", 256'(mv_cnt - mv0), 256'(exp_mv));
        check_eq("key", key, m_key);
        check_eq("key_mode", {254'd0, key_mode}, {254'd0, m_mode});
        check_eq("msg", {128'd0, msg}, {128'd0, m_msg});
        check_eq("res_ready_idle", {255'd0, res_ready}, {255'd0, phase == 2});
        check_eq("busy_idle", {255'd0, busy}, 256'd0);
`ifdef AES_SPI_FRAME_ERR_EN
        check_eq("frame_err_pulses", 256'(fe_cnt - fe0), 256'(exp_err));
        check_eq("err_cnt", {248'd0, err_cnt}, 256'(m_err));
`endif
    endtask

    task automatic offer_res(input logic [127:0] v);
        res       = v;
        res_valid = 1'b1;
        @(negedge clk);
        check_eq("res_ready_offer", {255'd0, res_ready}, {255'd0, phase == 2});
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        if (phase == 2) begin
            m_res = v;
            phase = 3;
        end
        tick(3);
        check_eq("res_ready_after", {255'd0, res_ready}, {255'd0, phase == 2});
    endtask

    task automatic gen(output logic [257:0] b);
        b = 258'd0;
        for (int k = 0; k < 9; k++) b = {b[225:0], 32'($urandom)};
    endtask

    task automatic rand_step();
        logic [257:0] b;
        logic [1:0]   md;
        int           n, need;
        bit           good;
        gen(b);
        good = ($urandom_range(0, 3) != 0);
        case (phase)
            0: begin
                md   = 2'($urandom_range(0, 3));
                need = (md == 2'b00) ? 130 : (md == 2'b01) ? 194 : 258;
                if (good && md != 2'b11) begin
                    n = need;
                end else begin
                    n = $urandom_range(100, 257);
                    if (n == need) n = n + 1;
                end
                b[n-1 -: 2] = md;
                run_frame(b, n);
            end
            1: begin
                n = good ? 128 : $urandom_range(100, 127);
                run_frame(b, n);
            end
            2: begin
                if (!good) run_frame(b, 128);
                else offer_res(b[127:0]);
            end
            default: begin
                n = good ? 128 : $urandom_range(8, 120);
                run_frame(b, n);
            end
        endcase
    endtask

    initial begin
        logic [127:0] mb;
        int           kv0;
        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        res = 128'd0; res_valid = 1'b0;
        model_reset();
        tick(3);
        check_zero("reset");
        rst = 1'b0;
        tick(5);

        offer_res(RES1);
        run_frame({128'd0, 2'b00, K128}, 130);
        check_eq("k128_literal", key, {K128, 128'd0});
        run_frame({130'd0, MSG1}, 128);
        check_eq("msg_literal", {128'd0, msg}, {128'd0, MSG1});
        offer_res(RES1);
        run_frame(258'd0, 128);

        run_frame({2'b10, K256}, 258);
        check_eq("k256_literal", key, K256);
        run_frame({130'd0, MSG1}, 128);
        run_frame({130'd0, ~MSG1}, 128);
        offer_res(~RES1);
        run_frame(258'd0, 40);
        run_frame(258'd0, 128);

        run_frame({64'd0, 2'b01, K192} >> 44, 150);
        run_frame({128'd0, 2'b11, K128}, 130);
        run_frame({64'd0, 2'b01, K192}, 194);
        check_eq("k192_mode", {254'd0, key_mode}, {254'd0, 2'b01});

        // Reset during bit 60 of a key frame, then a full key frame must be accepted.
        kv0 = kv_cnt;
        send_frame({128'd0, 2'b00, ~K128}, 130, 60, mb);
        check_eq("after_midrst_kv", 256'(kv_cnt - kv0), 256'd0);
        check_zero("after_midrst");
        run_frame({128'd0, 2'b00, ~K128}, 130);

        for (int it = 0; it < 14; it++) rand_step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
